weight_spad_loader: RTL and testbench

- Upstream feeder of the weight router scratchpad.
- Accepts a byte stream of weights over a valid/ready handshake and packs DATA_LENGTH bytes into one SPAD_DATA_WIDTH word, LSB lane first.
- Issues registered scratchpad write strobes at consecutive addresses from a programmable base, then raises a level done flag so the controller can start routing.
- Handles short transfers with zero-filled partial words, a word-count limit, and address wrap.

---
 rtl/weight_spad_loader.sv | 108 ++++++++++
 tb/tb_weight_spad_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_spad_loader.sv
// weight_spad_loader: packs a valid/ready byte stream of weights into scratchpad words
// written at consecutive, wrapping addresses, then raises a level done flag.
module weight_spad_loader #(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [ADDR_WIDTH:0]        i_word_count,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    input  logic                       i_last,
    output logic                       o_ready,
    output logic                       o_spad_write_en,
    output logic [ADDR_WIDTH-1:0]      o_spad_write_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic [ADDR_WIDTH:0]        o_words_written,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int LW = DATA_LENGTH > 1 ? $clog2(DATA_LENGTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      base_q;
    logic [ADDR_WIDTH:0]        count_q;
    logic [ADDR_WIDTH:0]        words_q;
    logic [LW-1:0]              lane_q;
    logic [SPAD_DATA_WIDTH-1:0] pack_q;
    logic [SPAD_DATA_WIDTH-1:0] pack_d;
    logic                       beat;
    logic                       complete;
    logic                       we_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [SPAD_DATA_WIDTH-1:0] data_q;
    logic                       busy_q;
    logic                       done_q;

    assign o_ready           = state_q == LOAD;
    assign beat              = i_valid & o_ready;
    assign complete          = beat & (i_last | (lane_q == LW'(DATA_LENGTH - 1)));
    assign o_spad_write_en   = we_q;
    assign o_spad_write_addr = addr_q;
    assign o_spad_data       = data_q;
    assign o_words_written   = words_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

    always_comb begin
        pack_d = pack_q;
        pack_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst | i_clear) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            words_q <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (i_start) begin
                    base_q  <= i_base_addr;
                    count_q <= i_word_count;
                    words_q <= '0;
                    lane_q  <= '0;
                    pack_q  <= '0;
                    done_q  <= i_word_count == '0;
                    busy_q  <= i_word_count != '0;
                    state_q <= i_word_count == '0 ? DONE : LOAD;
                end
                LOAD: if (complete) begin
                    // unfilled lanes are already zero because the pack register restarts clean
                    we_q    <= 1'b1;
                    addr_q  <= base_q + words_q[ADDR_WIDTH-1:0];
                    data_q  <= pack_d;
                    words_q <= words_q + 1'b1;
                    lane_q  <= '0;
                    pack_q  <= '0;
                    if (i_last || (words_q + 1'b1) == count_q) state_q <= DRAIN;
                end else if (beat) begin
                    pack_q <= pack_d;
                    lane_q <= lane_q + 1'b1;
                end
                DRAIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_spad_loader.sv
// tb_weight_spad_loader: random and directed stimulus checked every cycle against a
// transfer-level reference model of the loader.
module tb_weight_spad_loader;
    logic        i_clk = 1'b0;
    logic        i_rst, i_clear, i_start, i_valid, i_last;
    logic [7:0]  i_base_addr, i_data;
    logic [8:0]  i_word_count;
    logic        o_ready, o_spad_write_en, o_busy, o_done;
    logic [7:0]  o_spad_write_addr;
    logic [63:0] o_spad_data;
    logic [8:0]  o_words_written;

    int total = 0;
    int bad   = 0;

    bit          m_open, m_drain, m_done, m_we, m_acc;
    int          m_base, m_count, m_n, m_lane;
    logic [7:0]  m_bytes [8];
    logic [7:0]  m_addr;
    logic [63:0] m_data;

    logic [7:0]  log_addr [$];
    logic [63:0] log_data [$];

    weight_spad_loader dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_word_count(i_word_count), .i_data(i_data),
        .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
        .o_spad_write_en(o_spad_write_en), .o_spad_write_addr(o_spad_write_addr),
        .o_spad_data(o_spad_data), .o_words_written(o_words_written),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] packed_word();
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) w = w + (64'(m_bytes[i]) << (8 * i));
        return w;
    endfunction

    task automatic clear_bytes();
        for (int i = 0; i < 8; i++) m_bytes[i] = 8'h00;
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic s,
                        input logic [7:0] b, input logic [8:0] c, input logic r, input logic cl);
        i_valid = v; i_data = d; i_last = l; i_start = s;
        i_base_addr = b; i_word_count = c; i_rst = r; i_clear = cl;
        m_acc = 0;
        m_we  = 0;
        if (r || cl) begin
            m_open = 0; m_drain = 0; m_done = 0; m_n = 0; m_lane = 0;
            m_addr = '0; m_data = '0;
            clear_bytes();
        end else if (m_drain) begin
            m_drain = 0;
            m_done  = 1;
        end else if (m_open) begin
            if (v) begin
                m_acc = 1;
                m_bytes[m_lane] = d;
                m_lane++;
                if (m_lane == 8 || l) begin
                    m_we   = 1;
                    m_addr = 8'((m_base + m_n) % 256);
                    m_data = packed_word();
                    m_n++;
                    m_lane = 0;
                    clear_bytes();
                    if (l || m_n == m_count) begin
                        m_open  = 0;
                        m_drain = 1;
                    end
                end
            end
        end else if (s) begin
            m_base = int'(b); m_count = int'(c); m_n = 0; m_lane = 0;
            clear_bytes();
            m_done = (c == 0);
            m_open = (c != 0);
        end
        @(posedge i_clk);
        #1;
        check("write_en", 64'(o_spad_write_en), 64'(m_we));
        check("write_addr", 64'(o_spad_write_addr), 64'(m_addr));
        check("spad_data", o_spad_data, m_data);
        check("ready", 64'(o_ready), 64'(m_open));
        check("busy", 64'(o_busy), 64'(m_open | m_drain));
        check("done", 64'(o_done), 64'(m_done));
        check("words", 64'(o_words_written), 64'(m_n));
        if (o_spad_write_en) begin
            log_addr.push_back(o_spad_write_addr);
            log_data.push_back(o_spad_data);
        end
    endtask

    task automatic idle();
        tick(0, 8'($urandom), 0, 0, 8'($urandom), 9'($urandom), 0, 0);
    endtask

    task automatic start(input logic [7:0] b, input logic [8:0] c);
        tick(0, 8'($urandom), 0, 1, b, c, 0, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit gaps);
        for (int k = 0; k < 16; k++) begin
            tick(gaps ? ($urandom_range(0, 2) != 0) : 1'b1, d, l, 0,
                 8'($urandom), 9'($urandom), 0, 0);
            if (m_acc) return;
        end
        check("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // 1: two full words, continuous valid
        log_addr.delete(); log_data.delete();
        start(8'h10, 9'd2);
        for (int i = 1; i <= 16; i++) send(8'(i), i == 16, 0);
        idle(); idle();
        check("t1_nwrites", 64'(log_addr.size()), 64'd2);
        check("t1_addr0", 64'(log_addr[0]), 64'h10);
        check("t1_data0", log_data[0], 64'h0807060504030201);
        check("t1_addr1", 64'(log_addr[1]), 64'h11);
        check("t1_data1", log_data[1], 64'h100F0E0D0C0B0A09);
        check("t1_words", 64'(o_words_written), 64'd2);

        // 2: short transfer, partial word zero filled
        log_addr.delete(); log_data.delete();
        start(8'h20, 9'd4);
        send(8'hAA, 0, 0); send(8'hBB, 0, 0); send(8'hCC, 1, 0);
        check("t2_ready_drain", 64'(o_ready), 64'd0);
        idle(); idle();
        check("t2_nwrites", 64'(log_addr.size()), 64'd1);
        check("t2_addr", 64'(log_addr[0]), 64'h20);
        check("t2_data", log_data[0], 64'h0000000000CCBBAA);
        check("t2_words", 64'(o_words_written), 64'd1);

        // 3: word-count limit with address wrap and valid gaps
        log_addr.delete(); log_data.delete();
        start(8'hFE, 9'd3);
        for (int i = 0; i < 24; i++) send(8'($urandom), 0, 1);
        check("t3_ready_after", 64'(o_ready), 64'd0);
        tick(1, 8'h5A, 0, 0, 0, 0, 0, 0);
        check("t3_extra_accepted", 64'(m_acc), 64'd0);
        idle(); idle();
        check("t3_nwrites", 64'(log_addr.size()), 64'd3);
        check("t3_addr0", 64'(log_addr[0]), 64'hFE);
        check("t3_addr1", 64'(log_addr[1]), 64'hFF);
        check("t3_addr2", 64'(log_addr[2]), 64'h00);

        // 4: zero-word transfer
        log_addr.delete(); log_data.delete();
        start(8'h33, 9'd0);
        check("t4_done", 64'(o_done), 64'd1);
        idle(); idle();
        check("t4_nwrites", 64'(log_addr.size()), 64'd0);

        // 5: reset mid-word, then a clean restart
        start(8'h30, 9'd4);
        for (int i = 0; i < 13; i++) send(8'hE0 | 8'(i), 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 0);
        check("t5_rst_data", o_spad_data, 64'd0);
        idle();
        log_addr.delete(); log_data.delete();
        start(8'h40, 9'd1);
        for (int i = 0; i < 3; i++) send(8'h01 + 8'(i), i == 2, 0);
        idle(); idle();
        check("t5_addr", 64'(log_addr[0]), 64'h40);
        check("t5_data", log_data[0], 64'h0000000000030201);

        // 6: start ignored while loading, clear in DONE
        log_addr.delete(); log_data.delete();
        start(8'h50, 9'd2);
        for (int i = 0; i < 3; i++) send(8'($urandom), 0, 0);
        tick(0, 0, 0, 1, 8'h99, 9'd0, 0, 0);
        for (int i = 3; i < 16; i++) send(8'($urandom), i == 15, 1);
        idle(); idle();
        check("t6_addr0", 64'(log_addr[0]), 64'h50);
        check("t6_addr1", 64'(log_addr[1]), 64'h51);
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_clear_done", 64'(o_done), 64'd0);
        idle();

        // random transfers: lengths below, at and beyond the word-count limit
        for (int t = 0; t < 25; t++) begin
            int cnt, len;
            cnt = $urandom_range(1, 5);
            len = $urandom_range(1, cnt * 8 + 4);
            start(8'($urandom), 9'(cnt));
            for (int i = 0; i < len && m_open; i++) send(8'($urandom), i == len - 1, 1);
            if (!m_open && !m_drain) tick(1, 8'($urandom), 0, 0, 0, 0, 0, 0);
            repeat ($urandom_range(2, 3)) idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
